esc_interface: RTL and testbench

ESC_INTERFACE -- requirements
Module: esc_interface

---
 rtl/esc_interface_pkg.sv | 29 ++
 rtl/esc_interface.sv | 49 ++++
 tb/tb_esc_interface.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/esc_interface_pkg.sv
// Shared constants and types for the ESC PWM pulse generator.
// The counter type is wide enough to hold the longest pulse width.
package esc_interface_pkg;

    localparam int MIN_CLKS   = 6250;
    localparam int SPEED_MULT = 3;
    localparam int SPEED_W    = 11;
    localparam int CNT_W      = 14;

    typedef logic [SPEED_W-1:0] speed_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    // Shift-and-add against a constant multiplier; for 3 this folds to (s<<1)+s
    function automatic cnt_t pulse_clks(
        input speed_t      s,
        input int unsigned min_clks,
        input int unsigned mult
    );
        cnt_t acc;
        acc = cnt_t'(min_clks);
        for (int i = 0; i < 8; i++) begin
            if (mult[i]) begin
                acc = acc + (cnt_t'(s) << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/esc_interface.sv
// ESC PWM generator: wrt loads a down-counter with the pulse width
// and raises PWM; PWM falls when the registered count runs out.
module esc_interface #(
    parameter int MIN_CLKS   = esc_interface_pkg::MIN_CLKS,
    parameter int SPEED_MULT = esc_interface_pkg::SPEED_MULT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wrt,
    input  logic [esc_interface_pkg::SPEED_W-1:0] SPEED,
    output logic                                PWM
);

    import esc_interface_pkg::*;

    cnt_t n_clks;
    cnt_t cnt;
    cnt_t cnt_nxt;
    logic pwm_nxt;

    assign n_clks = pulse_clks(SPEED,
                               int'(MIN_CLKS),
                               int'(SPEED_MULT));

    // wrt wins over the natural end so a restart never glitches low
    always_comb begin
        cnt_nxt = cnt;
        pwm_nxt = PWM;
        if (wrt) begin
            cnt_nxt = n_clks;
            pwm_nxt = 1'b1;
        end else if (PWM) begin
            cnt_nxt = (cnt == '0) ? '0 : cnt - cnt_t'(1);
            pwm_nxt = (cnt > cnt_t'(1));
        end
    end

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt <= '0;
            PWM <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            PWM <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_esc_interface.sv
// Self-checking bench for esc_interface against an end-time pulse model.
// Directed pulse widths, restarts, reset aborts and randomized retriggers.
module tb_esc_interface;

    import esc_interface_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        wrt   = 1'b0;
    logic [10:0] SPEED = '0;
    logic        PWM;

    int n_chk    = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int end_edge = 0;

    always #5 clk = ~clk;

    esc_interface dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wrt   (wrt),
        .SPEED (SPEED),
        .PWM   (PWM)
    );

    function automatic int ref_n(input int s);
        return MIN_CLKS + SPEED_MULT * s;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Model: a pulse started at edge e is high until edge e+N
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            end_edge = edge_n;
        end else begin
            edge_n = edge_n + 1;
            if (wrt) end_edge = edge_n + ref_n(int'(SPEED));
        end
    end

    always @(negedge clk) begin
        chk("pwm_model", int'(PWM), int'(edge_n < end_edge));
    end

    // Start at s1; optionally retrigger with s2 after k high cycles
    task automatic retrig(input string tag, input int s1, input int k,
                          input int s2, input int spd_after);
        int cnt;
        int exp;
        cnt   = 0;
        SPEED = 11'(s1);
        wrt   = 1'b1;
        @(negedge clk);
        wrt   = 1'b0;
        SPEED = 11'(spd_after);
        while (PWM && cnt < 40000) begin
            cnt++;
            if (k != 0 && cnt == k) begin
                wrt   = 1'b1;
                SPEED = 11'(s2);
            end else begin
                wrt   = 1'b0;
                SPEED = 11'(spd_after);
            end
            @(negedge clk);
        end
        wrt = 1'b0;
        exp = (k == 0) ? ref_n(s1) : k + ref_n(s2);
        chk(tag, cnt, exp);
        repeat (5) @(negedge clk);
        chk({tag, "_idle"}, int'(PWM), 0);
    endtask

    initial begin
        int s;
        rst_n = 1'b1;
        wrt   = 1'b1;
        SPEED = 11'd2047;
        repeat (4) @(negedge clk);
        chk("rst_pwm", int'(PWM), 0);
        wrt   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", int'(PWM), 0);

        retrig("w_s0_spdchg", 0, 0, 0, 2047);
        retrig("w_s552", 552, 0, 0, 0);
        retrig("w_s2047", 2047, 0, 0, 0);
        retrig("restart", 0, 3000, 100, 0);
        retrig("end_tie", 0, 6250, 5, 0);

        s = 0;
        for (int i = 0; i < 50; i++) begin
            s     = int'($urandom_range(0, 100));
            SPEED = 11'(s);
            wrt   = 1'b1;
            @(negedge clk);
            chk("held", int'(PWM), 1);
        end
        wrt = 1'b0;
        repeat (ref_n(s) + 5) @(negedge clk);
        chk("held_end", int'(PWM), 0);

        SPEED = 11'd2047;
        wrt   = 1'b1;
        @(negedge clk);
        wrt   = 1'b0;
        repeat (499) @(negedge clk);
        chk("pre_rst", int'(PWM), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rst_async", int'(PWM), 0);
        wrt = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wrt_ignored", int'(PWM), 0);
        wrt   = 1'b0;
        rst_n = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_after", int'(PWM), 0);

        for (int i = 0; i < 2; i++) begin
            retrig("rand_retrig",
                   int'($urandom_range(0, 2047)),
                   int'($urandom_range(1, 500)),
                   int'($urandom_range(0, 300)),
                   int'($urandom_range(0, 2047)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
